mac_array: RTL and testbench

MAC_ARRAY -- requirements
Module: mac_array

---
 rtl/mac_array.sv | 151 +++++++++++++++
 tb/tb_mac_array.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array.sv
// Multi-lane multiply-accumulate engine: K coefficient-weighted beats per result feed
// LANES saturating accumulators; results leave through a valid/ready output register.
module mac_array #(
  parameter  int LANES = 4,
  parameter  int DW    = 8,
  parameter  int CW    = 7,
  parameter  int K     = 8,
  parameter  int NOUT  = 32,
  parameter  int ACCW  = 18,
  localparam int AW    = (K * NOUT / 2 > 1) ? $clog2(K * NOUT / 2) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  signed_mode,
  input  logic [2*CW-1:0]       coef,
  input  logic [LANES*DW-1:0]   x_data,
  input  logic                  x_valid,
  output logic                  x_ready,
  output logic                  x_shift,
  output logic [AW-1:0]         rom_addr,
  output logic [LANES*ACCW-1:0] acc_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int TW = (K > 1) ? $clog2(K) : 1;
  localparam int RW = (NOUT > 1) ? $clog2(NOUT) : 1;
  // Sum width holds the largest accumulator plus the largest product with sign headroom.
  localparam int SW = ((ACCW > DW + CW) ? ACCW : DW + CW) + 2;

  localparam logic [AW-1:0] ADDR_LAST = AW'(K * NOUT / 2 - 1);
  localparam logic [TW-1:0] TAP_LAST  = TW'(K - 1);
  localparam logic [RW-1:0] RES_LAST  = RW'(NOUT - 1);

  localparam logic signed [SW-1:0] UMAX = {{(SW-ACCW){1'b0}}, {ACCW{1'b1}}};
  localparam logic signed [SW-1:0] SMAX = {{(SW-ACCW+1){1'b0}}, {(ACCW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW-ACCW+1){1'b1}}, {(ACCW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                r_state, w_state_next;
  logic [TW-1:0]         r_tap;
  logic [RW-1:0]         r_res;
  logic [AW-1:0]         r_rom_addr;
  logic [LANES*ACCW-1:0] r_acc, r_acc_out, w_sat;
  logic                  r_out_valid, r_x_shift, r_done, r_signed;
  logic                  w_x_ready, w_beat, w_out_hs, w_last_tap, w_last_res;
  logic [CW-1:0]         w_coef;

  assign w_last_tap = (r_tap == TAP_LAST);
  assign w_last_res = (r_res == RES_LAST);
  assign w_out_hs   = r_out_valid && out_ready;
  // The final tap stalls while an unconsumed result still occupies acc_out.
  assign w_x_ready  = (r_state == RUN) && !(w_last_tap && r_out_valid && !out_ready);
  assign w_beat     = x_valid && w_x_ready;
  assign w_coef     = r_tap[0] ? coef[CW-1:0] : coef[2*CW-1:CW];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DW-1:0]        w_x;
    logic [ACCW-1:0]      w_acc;
    logic signed [SW-1:0] w_x_ext, w_c_ext, w_base, w_sum;

    assign w_x     = x_data[g*DW +: DW];
    assign w_acc   = r_acc[g*ACCW +: ACCW];
    assign w_x_ext = {{(SW-DW){r_signed & w_x[DW-1]}}, w_x};
    assign w_c_ext = {{(SW-CW){r_signed & w_coef[CW-1]}}, w_coef};
    assign w_base  = (r_tap == '0) ? '0 : {{(SW-ACCW){r_signed & w_acc[ACCW-1]}}, w_acc};
    assign w_sum   = w_base + w_x_ext * w_c_ext;

    assign w_sat[g*ACCW +: ACCW] =
      r_signed ? ((w_sum > SMAX) ? SMAX[ACCW-1:0] :
                  (w_sum < SMIN) ? SMIN[ACCW-1:0] : w_sum[ACCW-1:0])
               : ((w_sum > UMAX) ? UMAX[ACCW-1:0] :
                  w_sum[SW-1]    ? '0             : w_sum[ACCW-1:0]);
  end

  always_comb begin
    // NOTE: defaulting the next state first keeps every path assigned, so no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_beat && w_last_tap && w_last_res) w_state_next = DRAIN;
      DRAIN:   if (w_out_hs) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (clear) w_state_next = IDLE;
  end

  // NOTE: sequential state uses <= so every register samples values from before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tap       <= '0;
      r_res       <= '0;
      r_rom_addr  <= '0;
      r_acc       <= '0;
      r_acc_out   <= '0;
      r_out_valid <= 1'b0;
      r_x_shift   <= 1'b0;
      r_done      <= 1'b0;
      r_signed    <= 1'b0;
    end else if (clear) begin
      r_tap       <= '0;
      r_res       <= '0;
      r_rom_addr  <= '0;
      r_acc       <= '0;
      r_acc_out   <= '0;
      r_out_valid <= 1'b0;
      r_x_shift   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_x_shift <= w_beat;
      r_done    <= (r_state == DRAIN) && w_out_hs;
      if (r_state == IDLE && start) begin
        r_signed   <= signed_mode;
        r_tap      <= '0;
        r_res      <= '0;
        r_rom_addr <= '0;
      end
      if (w_beat) begin
        r_acc <= w_sat;
        r_tap <= w_last_tap ? '0 : r_tap + TW'(1);
        if (r_tap[0]) r_rom_addr <= (r_rom_addr == ADDR_LAST) ? '0 : r_rom_addr + AW'(1);
        if (w_last_tap) r_res <= w_last_res ? '0 : r_res + RW'(1);
      end
      if (w_beat && w_last_tap) begin
        r_acc_out   <= w_sat;
        r_out_valid <= 1'b1;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign x_ready   = w_x_ready;
  assign x_shift   = r_x_shift;
  assign rom_addr  = r_rom_addr;
  assign acc_out   = r_acc_out;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_mac_array.sv
// Randomized bench for mac_array: two instances (ACCW 18 and 10) share stimulus and are
// scored against a plain-arithmetic saturating reference with an expected-result queue.
module tb_mac_array;

  localparam int LANES  = 4;
  localparam int DW     = 8;
  localparam int CW     = 7;
  localparam int K      = 8;
  localparam int NOUT   = 32;
  localparam int ACCW0  = 18;
  localparam int ACCW1  = 10;
  localparam int TOTAL  = K * NOUT;
  localparam int ROMN   = K * NOUT / 2;
  localparam int AW     = $clog2(ROMN);
  localparam int BUDGET = 3000;

  logic clk, rst, start, clear, signed_mode, x_valid, out_ready;
  logic [2*CW-1:0]      coef;
  logic [LANES*DW-1:0]  x_data;

  logic                   x_ready0, x_shift0, out_valid0, busy0, done0;
  logic [AW-1:0]          rom_addr0;
  logic [LANES*ACCW0-1:0] acc_out0;
  logic                   x_ready1, x_shift1, out_valid1, busy1, done1;
  logic [AW-1:0]          rom_addr1;
  logic [LANES*ACCW1-1:0] acc_out1;

  logic [2*CW-1:0]        rom [ROMN];
  longint                 m0 [LANES];
  longint                 m1 [LANES];
  logic [LANES*ACCW0-1:0] q0 [$];
  logic [LANES*ACCW1-1:0] q1 [$];
  logic [LANES*ACCW0-1:0] last0;
  logic [LANES*ACCW1-1:0] last1;
  int n_checks = 0;
  int n_pass   = 0;

  assign coef = rom[rom_addr0];

  mac_array u_dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .signed_mode(signed_mode),
    .coef(coef), .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready0),
    .x_shift(x_shift0), .rom_addr(rom_addr0), .acc_out(acc_out0),
    .out_valid(out_valid0), .out_ready(out_ready), .busy(busy0), .done(done0)
  );

  mac_array #(.ACCW(ACCW1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .signed_mode(signed_mode),
    .coef(coef), .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready1),
    .x_shift(x_shift1), .rom_addr(rom_addr1), .acc_out(acc_out1),
    .out_valid(out_valid1), .out_ready(out_ready), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic longint ext(input logic [7:0] v, input int w, input bit sgn);
    longint r;
    r = longint'(v) & ((longint'(1) << w) - 1);
    if (sgn && v[w-1]) r = r - (longint'(1) << w);
    return r;
  endfunction

  function automatic longint sat(input longint v, input int w, input bit sgn);
    longint hi, lo;
    hi = sgn ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
    lo = sgn ? -(longint'(1) << (w - 1)) : 0;
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  task automatic fill_rom(input int first, input int second, input bit rnd);
    for (int i = 0; i < ROMN; i++)
      rom[i] = rnd ? 14'($urandom) : {7'(first), 7'(second)};
  endtask

  // Reference: beat b of a job is tap b%K of result b/K, using ROM word b/2.
  task automatic model_beat(input int b, input bit sgn);
    int tap;
    logic [CW-1:0] c;
    logic [DW-1:0] xv;
    longint p;
    logic [LANES*ACCW0-1:0] e0;
    logic [LANES*ACCW1-1:0] e1;
    tap = b % K;
    c = (tap % 2 == 0) ? rom[(b / 2) % ROMN][2*CW-1:CW] : rom[(b / 2) % ROMN][CW-1:0];
    for (int l = 0; l < LANES; l++) begin
      xv = x_data[l*DW +: DW];
      p  = ext(xv, DW, sgn) * ext({1'b0, c}, CW, sgn);
      if (tap == 0) begin
        m0[l] = 0;
        m1[l] = 0;
      end
      m0[l] = sat(m0[l] + p, ACCW0, sgn);
      m1[l] = sat(m1[l] + p, ACCW1, sgn);
      e0[l*ACCW0 +: ACCW0] = m0[l][ACCW0-1:0];
      e1[l*ACCW1 +: ACCW1] = m1[l][ACCW1-1:0];
    end
    if (tap == K - 1) begin
      q0.push_back(e0);
      q1.push_back(e1);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_acc0"}, acc_out0, 0);
    check({tag, "_acc1"}, acc_out1, 0);
    check({tag, "_rom"}, {rom_addr1, rom_addr0}, 0);
    check({tag, "_valid"}, {out_valid1, out_valid0}, 0);
    check({tag, "_ready"}, {x_ready1, x_ready0}, 0);
    check({tag, "_shift"}, {x_shift1, x_shift0}, 0);
    check({tag, "_busy"}, {busy1, busy0}, 0);
    check({tag, "_done"}, {done1, done0}, 0);
  endtask

  task automatic run_job(input bit sgn, input bit xfix_en, input logic [7:0] xfix,
                         input int vpct, input int rpct, input int stall_beat,
                         input int abort_beat, input bit abort_clr);
    int beats, cyc, stall_left, tap;
    bit prev_beat, prev_hold, stall_done, exp_rdy, beat;
    logic [LANES*ACCW0-1:0] prev_acc;
    beats = 0; cyc = 0; stall_left = 0;
    prev_beat = 0; prev_hold = 0; stall_done = 0; prev_acc = '0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    signed_mode = sgn; start = 1; x_valid = 0; out_ready = 1;
    @(negedge clk);
    start = 0;
    while ((beats < TOTAL || q0.size() > 0) && cyc < BUDGET) begin
      if (beats == abort_beat) begin
        x_valid = 1; start = 0; out_ready = 1;
        if (abort_clr) begin
          clear = 1;
          @(negedge clk);
          clear = 0; x_valid = 0;
          check_quiet("after_clear");
        end else begin
          #2 rst = 0;
          #1 check_quiet("in_reset");
          @(negedge clk);
          rst = 1; x_valid = 0;
        end
        return;
      end
      x_valid = ($urandom_range(99) < vpct);
      for (int l = 0; l < LANES; l++) x_data[l*DW +: DW] = xfix_en ? xfix : 8'($urandom);
      if (stall_beat >= 0 && !stall_done && beats >= stall_beat) begin
        stall_left = 20;
        stall_done = 1;
      end
      if (stall_left > 0) begin
        out_ready = 0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(99) < rpct);
      end
      start = (beats > K && beats < TOTAL - 2 * K && $urandom_range(9) == 0);
      #1;
      tap = beats % K;
      exp_rdy = (beats < TOTAL) && !(tap == K - 1 && q0.size() > 0 && !out_ready);
      check("x_ready", x_ready0, exp_rdy);
      check("out_valid", {out_valid1, out_valid0}, {q1.size() != 0, q0.size() != 0});
      check("busy", busy0, 1);
      check("done_early", done0, 0);
      check("x_shift", x_shift0, prev_beat);
      if (prev_hold) check("acc_hold", acc_out0, prev_acc);
      prev_hold = out_valid0 && !out_ready;
      prev_acc  = acc_out0;
      if (out_valid0 && out_ready && q0.size() > 0) begin
        check("acc_out_w18", acc_out0, q0[0]);
        check("acc_out_w10", acc_out1, q1[0]);
        last0 = acc_out0;
        last1 = acc_out1;
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      beat = x_valid && exp_rdy;
      if (beat) begin
        check("rom_addr", rom_addr0, (beats / 2) % ROMN);
        model_beat(beats, sgn);
        beats++;
      end
      prev_beat = beat;
      @(negedge clk);
      cyc++;
    end
    start = 0; x_valid = 0;
    check("job_in_budget", cyc < BUDGET, 1);
    check("done_pulse", {done1, done0}, 2'b11);
    check("done_not_busy", busy0, 0);
    check("rom_wrapped", rom_addr0, 0);
    @(negedge clk);
    check("done_one_cycle", done0, 0);
  endtask

  initial begin
    rst = 0; start = 0; clear = 0; signed_mode = 0;
    x_valid = 0; x_data = '0; out_ready = 0;
    last0 = '0; last1 = '0;
    fill_rom(0, 0, 1);
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1;
    x_valid = 1; x_data = '1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("idle_x_ready", x_ready0, 0);
      check("idle_x_shift", x_shift0, 0);
      check("idle_busy", busy0, 0);
    end
    x_valid = 0;

    fill_rom(2, 3, 0);
    run_job(0, 1, 8'h01, 100, 100, -1, -1, 0);
    check("basic_result", last0, {LANES{18'd20}});

    fill_rom(3, 3, 0);
    run_job(1, 1, 8'hFF, 100, 100, -1, -1, 0);
    check("signed_result", last0, {LANES{18'h3FFE8}});
    check("signed_result_w10", last1, {LANES{10'h3E8}});

    fill_rom(127, 127, 0);
    run_job(0, 1, 8'hFF, 100, 100, -1, -1, 0);
    check("sat_result_w10", last1, {LANES{10'h3FF}});
    check("nosat_result_w18", last0, {LANES{18'd259080}});

    fill_rom(2, 3, 0);
    run_job(0, 1, 8'h01, 100, 100, K, -1, 0);
    check("stall_result", last0, {LANES{18'd20}});

    fill_rom(0, 0, 1);
    run_job(0, 0, 8'h00, 75, 70, -1, -1, 0);
    run_job(1, 0, 8'h00, 75, 70, -1, -1, 0);

    fill_rom(2, 3, 0);
    run_job(0, 1, 8'h01, 100, 100, -1, 5 * K + 3, 0);
    run_job(0, 1, 8'h01, 100, 100, -1, -1, 0);
    check("post_reset_result", last0, {LANES{18'd20}});

    fill_rom(0, 0, 1);
    run_job(1, 0, 8'h00, 90, 90, -1, 10 * K, 1);
    run_job(1, 0, 8'h00, 90, 90, -1, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
